// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: register file bus width and the dump reader state encoding.
package cpu_pkg;

    // Register file data bus width (data MSB is BUS_WIDTH-1 = 7)
    localparam int BUS_WIDTH = 8;

    // States of the register dump sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage : cpu_pkg

// File: rtl/cpu_register_dump_reader.sv
// Walks an inclusive (possibly wrapping) range of CPU registers through one
// read port of the register file and streams each value out with a
// valid/ready handshake, tagging every word with its register index.
module cpu_register_dump_reader
    import cpu_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = 256,
    localparam int ADDR_W = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    first_address_in,
    input  logic [ADDR_W-1:0]    last_address_in,
    output logic [ADDR_W-1:0]    read_register_address_out,
    input  logic [BUS_WIDTH-1:0] read_data_in,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic [ADDR_W-1:0]    address_tag_out,
    output logic                 data_valid_out,
    input  logic                 data_ready_in,
    output logic                 last_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUMBER_OF_REGISTERS - 1);

    dump_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    current_addr_q, current_addr_d;
    logic [ADDR_W-1:0]    end_addr_q, end_addr_d;
    logic [ADDR_W-1:0]    read_addr_q, read_addr_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [ADDR_W-1:0]    tag_q, tag_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ADDR_W-1:0]    next_addr;

    // Next register index, wrapping at the top of the register file even when its size is not a power of two
    always_comb begin
        next_addr = (current_addr_q == LAST_INDEX) ? '0 : current_addr_q + 1'b1;
    end

    // Sequencer next-state and registered-output logic; every output is a flop so the consumer sees glitch-free signals
    always_comb begin
        state_d        = state_q;
        current_addr_d = current_addr_q;
        end_addr_d     = end_addr_q;
        read_addr_d    = read_addr_q;
        data_d         = data_q;
        tag_d          = tag_q;
        valid_d        = valid_q;
        last_d         = last_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    current_addr_d = first_address_in;
                    end_addr_d     = last_address_in;
                    read_addr_d    = first_address_in;
                    busy_d         = 1'b1;
                    state_d        = FETCH;
                end
            end
            FETCH: begin
                data_d  = read_data_in;
                tag_d   = current_addr_q;
                valid_d = 1'b1;
                last_d  = (current_addr_q == end_addr_q);
                state_d = SEND;
            end
            SEND: begin
                if (data_ready_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (current_addr_q == end_addr_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        current_addr_d = next_addr;
                        read_addr_d    = next_addr;
                        state_d        = FETCH;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any dump in progress
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q        <= IDLE;
            current_addr_q <= '0;
            end_addr_q     <= '0;
            read_addr_q    <= '0;
            data_q         <= '0;
            tag_q          <= '0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            current_addr_q <= current_addr_d;
            end_addr_q     <= end_addr_d;
            read_addr_q    <= read_addr_d;
            data_q         <= data_d;
            tag_q          <= tag_d;
            valid_q        <= valid_d;
            last_q         <= last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign read_register_address_out = read_addr_q;
    assign data_out                  = data_q;
    assign address_tag_out           = tag_q;
    assign data_valid_out            = valid_q;
    assign last_out                  = last_q;
    assign busy_out                  = busy_q;
    assign done_out                  = done_q;

endmodule : cpu_register_dump_reader

// File: doc/cpu_register_dump_reader.md
CPU_REGISTER_DUMP_READER -- requirements
Module: cpu_register_dump_reader

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_REGISTERS, default 256; it is the number of registers in the attached CPU register file.
REQ-002 The block SHALL have localparam ADDR_W = $clog2(NUMBER_OF_REGISTERS), the address width; data width SHALL be 8 bits, matching the register file bus.
REQ-003 The block SHALL have port clock_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset_in, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start_in, input, 1 bit: request a dump; sampled only in IDLE.
REQ-006 The block SHALL have port first_address_in, input, ADDR_W bits: first register of the range.
REQ-007 The block SHALL have port last_address_in, input, ADDR_W bits: final register of the range (inclusive).
REQ-008 The block SHALL have port read_register_address_out, output, ADDR_W bits: drives the register file read-address port.
REQ-009 The block SHALL have port read_data_in, input, 8 bits: combinational read data returned for read_register_address_out.
REQ-010 The block SHALL have port data_out, output, 8 bits: streamed register value.
REQ-011 The block SHALL have port address_tag_out, output, ADDR_W bits: register index of the current data_out.
REQ-012 The block SHALL have port data_valid_out, output, 1 bit: data_out, address_tag_out and last_out are valid.
REQ-013 The block SHALL have port data_ready_in, input, 1 bit: the consumer accepts the word this cycle.
REQ-014 The block SHALL have port last_out, output, 1 bit: the current word is the final word of the range.
REQ-015 The block SHALL have port busy_out, output, 1 bit: a dump is in progress.
REQ-016 The block SHALL have port done_out, output, 1 bit: one-cycle pulse after the final word is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SEND and DONE.
REQ-018 In IDLE with start_in=1, the block SHALL latch first_address_in into current_addr and last_address_in into end_addr, then go to FETCH on the next edge.
REQ-019 In FETCH, the block SHALL drive read_register_address_out=current_addr, capture read_data_in into the data holding register at the edge, and go to SEND.
REQ-020 In SEND, data_valid_out SHALL be 1; data_out and address_tag_out SHALL hold the captured value and index, stable until accepted.
REQ-021 A transfer SHALL occur on an edge where data_valid_out=1 and data_ready_in=1; on a transfer, data_valid_out SHALL deassert the next cycle.
REQ-022 On a transfer with current_addr==end_addr, the block SHALL go to DONE; on any other transfer it SHALL increment current_addr and go to FETCH.
REQ-023 In DONE, done_out SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-024 When start_in is sampled at edge N, the first data_valid_out SHALL be high in cycle N+2. Throughput SHALL be one word per 2 cycles when data_ready_in is held high.
REQ-025 The address increment SHALL be modulo NUMBER_OF_REGISTERS, so NUMBER_OF_REGISTERS-1 wraps to 0; first>last SHALL yield a wrapped range.
REQ-026 When first==last, the block SHALL send exactly one word, with last_out=1.
REQ-027 last_out SHALL equal (data_valid_out && address_tag_out==end_addr).
REQ-028 busy_out SHALL be 1 in FETCH, SEND and DONE, and 0 in IDLE.
REQ-029 start_in SHALL be ignored outside IDLE; first_address_in and last_address_in SHALL be don't-care after being latched.
REQ-030 In SEND with data_ready_in=0 indefinitely, the block SHALL hold all outputs and never drop a word.
REQ-031 In IDLE and DONE, read_register_address_out SHALL hold its last value; data_out may hold stale data while data_valid_out=0.

Reset
REQ-032 Reset SHALL be synchronous and active-high: reset_in=1 at a rising edge forces state IDLE.
REQ-033 On reset, all of the following SHALL be 0: current_addr, end_addr, data_out, address_tag_out, read_register_address_out, data_valid_out, last_out, busy_out and done_out.
REQ-034 Reset mid-dump, in any state, SHALL abort the dump with no done_out pulse; reset SHALL take priority over start_in and transfers.

Structure
REQ-035 A shared package cpu_pkg SHALL hold the BUS_WIDTH constant (data MSB = 7) and the dump_state_t enum {IDLE, FETCH, SEND, DONE}.
REQ-036 The block SHALL be a single module with no sub-modules; it connects to one read port of cpu_register_file.

Verification
REQ-037 Scenario: preload regs 3..6 = 0x11,0x22,0x33,0x44; first=3, last=6; ready held 1 -> words 0x11..0x44 with tags 3..6; first valid at N+2; last_out only on tag 6; done_out one cycle after it.
REQ-038 Scenario: first=last=9, reg9=0xA5 -> a single word 0xA5 with last_out=1, then done_out.
REQ-039 Scenario: first=254, last=1 with 256 registers -> tags 254, 255, 0, 1 in order; reg0 reads 0x00.
REQ-040 Scenario: ready held low 10 cycles during the second word -> data, tag and valid stay stable; no word is lost or duplicated once ready rises.
REQ-041 Scenario: start pulsed while busy -> ignored, and the current dump completes unchanged.
REQ-042 Scenario: reset asserted in SEND -> the next cycle has all outputs 0 and state IDLE, with no done_out; a new start then works normally.
